// File: rtl/memb_pkg.sv
// Shared state encoding and sizing helper for the memB skew stream buffer.
package memb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } memb_state_t;

    // Bits needed to hold any count in 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/memb_skew_lane.sv
// One skew lane: a DEPTH-deep shift register of signed elements, q is the tail.
module memb_skew_lane #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DEPTH   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift,
    input  logic                      clear,
    input  logic signed [BITS_AB-1:0] d,
    output logic signed [BITS_AB-1:0] q
);

    logic [DEPTH-1:0][BITS_AB-1:0] stage_q;
    logic [DEPTH-1:0][BITS_AB-1:0] stage_d;

    // Clear wins over shift so a new matrix never inherits stale data.
    always_comb begin
        stage_d = stage_q;
        if (clear) begin
            stage_d = '0;
        end else if (shift) begin
            stage_d[0] = d;
            for (int unsigned j = 1; j < DEPTH; j++) begin
                stage_d[j] = stage_q[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/memb_skew_stream.sv
// B-operand skew buffer: loads num_rows rows, emits them skewed by lane, drains, pulses done.
// Optional abort input when MEMB_ABORT_EN is defined.
module memb_skew_stream
    import memb_pkg::*;
#(
    parameter  int unsigned BITS_AB  = 8,
    parameter  int unsigned DIM      = 8,
    parameter  int unsigned ROWS_MAX = 16,
    localparam int unsigned ROW_W    = cnt_w(ROWS_MAX)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic        [ROW_W-1:0]           num_rows,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DIM-1:0][BITS_AB-1:0] Bin,
`ifdef MEMB_ABORT_EN
    input  logic                              abort,
`endif
    output logic                              out_valid,
    output logic signed [DIM-1:0][BITS_AB-1:0] Bout,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned DRN_W = cnt_w(DIM);

    typedef logic signed [BITS_AB-1:0] elem_t;

    memb_state_t      state_q, state_d;
    logic [ROW_W-1:0] rows_left_q, rows_left_d;
    logic [DRN_W-1:0] drain_left_q, drain_left_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic             step_c;
    logic             clear_c;
    logic             abort_c;

    elem_t            lane_in [DIM];
    elem_t            lane_tail [DIM];

`ifdef MEMB_ABORT_EN
    assign abort_c = abort && (state_q != IDLE);
`else
    assign abort_c = 1'b0;
`endif

    // Sequencer: IDLE -> FILL (one step per accepted row) -> DRAIN (DIM-1 zero steps) -> IDLE.
    always_comb begin
        state_d      = state_q;
        rows_left_d  = rows_left_q;
        drain_left_d = drain_left_q;
        step_c       = 1'b0;
        clear_c      = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && (num_rows != '0)) begin
                    clear_c     = 1'b1;
                    rows_left_d = (num_rows > ROW_W'(ROWS_MAX)) ? ROW_W'(ROWS_MAX) : num_rows;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (in_valid && in_ready_q) begin
                    step_c      = 1'b1;
                    rows_left_d = rows_left_q - ROW_W'(1);
                    if (rows_left_q == ROW_W'(1)) begin
                        if (DIM > 1) begin
                            state_d      = DRAIN;
                            drain_left_d = DRN_W'(DIM - 1);
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                step_c       = 1'b1;
                drain_left_d = drain_left_q - DRN_W'(1);
                if (drain_left_q == DRN_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_c) begin
            state_d = IDLE;
            clear_c = 1'b1;
            step_c  = 1'b0;
            done_d  = 1'b0;
        end

        out_valid_d = step_c;
        in_ready_d  = (state_d == FILL);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rows_left_q  <= '0;
            drain_left_q <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_left_q  <= rows_left_d;
            drain_left_q <= drain_left_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Lane i is i+1 deep; zeros are shifted in once the last row has been taken.
    for (genvar i = 0; i < int'(DIM); i++) begin : g_lane
        assign lane_in[i] = (state_q == FILL) ? elem_t'(Bin[i]) : elem_t'(0);

        memb_skew_lane #(
            .BITS_AB (BITS_AB),
            .DEPTH   (i + 1)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .shift (step_c),
            .clear (clear_c),
            .d     (lane_in[i]),
            .q     (lane_tail[i])
        );

        assign Bout[i] = lane_tail[i];
    end

    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_memb_skew_stream.sv
// Directed and randomized bench for memb_skew_stream with a row/step reference model.
module tb_memb_skew_stream;

    localparam int unsigned BITS_AB  = 8;
    localparam int unsigned DIM      = 8;
    localparam int unsigned ROWS_MAX = 16;
    localparam int unsigned ROW_W    = $clog2(ROWS_MAX + 1);
    localparam int unsigned BW       = DIM * BITS_AB;

    logic                               clk;
    logic                               rst;
    logic                               start;
    logic        [ROW_W-1:0]            num_rows;
    logic                               in_valid;
    logic                               in_ready;
    logic signed [DIM-1:0][BITS_AB-1:0] bin;
    logic                               out_valid;
    logic signed [DIM-1:0][BITS_AB-1:0] bout;
    logic                               busy;
    logic                               done;
`ifdef MEMB_ABORT_EN
    logic                               abort;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [BW-1:0] rows [ROWS_MAX];
    int            gaps [ROWS_MAX];

    memb_skew_stream #(
        .BITS_AB  (BITS_AB),
        .DIM      (DIM),
        .ROWS_MAX (ROWS_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Bin       (bin),
`ifdef MEMB_ABORT_EN
        .abort     (abort),
`endif
        .out_valid (out_valid),
        .Bout      (bout),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // After t completed steps, lane i shows the row taken on step t-1-i (or 0 if none).
    function automatic logic [BW-1:0] exp_bout(input int t, input int n);
        logic [BW-1:0] v;
        int r;
        v = '0;
        for (int i = 0; i < int'(DIM); i++) begin
            r = t - 1 - i;
            if (r >= 0 && r < n) begin
                v[i*BITS_AB +: BITS_AB] = rows[r][i*BITS_AB +: BITS_AB];
            end
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_row();
        logic [BW-1:0] v;
        for (int i = 0; i < int'(DIM); i++) begin
            v[i*BITS_AB +: BITS_AB] = BITS_AB'($urandom);
        end
        return v;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_bout"},      bout, '0);
        chk({tag, "_out_valid"}, BW'(out_valid), '0);
        chk({tag, "_in_ready"},  BW'(in_ready), '0);
        chk({tag, "_busy"},      BW'(busy), '0);
        chk({tag, "_done"},      BW'(done), '0);
    endtask

    task automatic clear_gaps();
        for (int r = 0; r < int'(ROWS_MAX); r++) gaps[r] = 0;
    endtask

    // One full matrix: start, feed rows (with idle gaps), drain, return to idle.
    task automatic run_matrix(input int n_req, input bit rand_gaps, input bit start_spam);
        int n, t, gc, total;
        n     = (n_req > int'(ROWS_MAX)) ? int'(ROWS_MAX) : n_req;
        total = n + int'(DIM) - 1;
        t     = 0;
        chk("idle_in_ready", BW'(in_ready), '0);
        start    = 1'b1;
        num_rows = ROW_W'(n_req);
        in_valid = 1'b0;
        tick();
        start    = start_spam;
        num_rows = ROW_W'(5);
        chk("start_busy", BW'(busy), BW'(1));
        chk("start_out_valid", BW'(out_valid), '0);
        chk("start_bout", bout, exp_bout(0, n));
        for (int acc = 0; acc < n; acc++) begin
            gc = rand_gaps ? int'($urandom_range(0, 2)) : gaps[acc];
            for (int g = 0; g < gc; g++) begin
                in_valid = 1'b0;
                bin      = rand_row();
                tick();
                chk($sformatf("gap_out_valid t=%0d", t), BW'(out_valid), '0);
                chk($sformatf("gap_bout t=%0d", t), bout, exp_bout(t, n));
                chk("gap_in_ready", BW'(in_ready), BW'(1));
            end
            chk("fill_in_ready", BW'(in_ready), BW'(1));
            in_valid = 1'b1;
            bin      = rows[acc];
            tick();
            t++;
            chk($sformatf("fill_out_valid t=%0d", t), BW'(out_valid), BW'(1));
            chk($sformatf("fill_bout t=%0d", t), bout, exp_bout(t, n));
            chk($sformatf("fill_done t=%0d", t), BW'(done), BW'(t == total));
            chk($sformatf("fill_in_ready_after t=%0d", t), BW'(in_ready), BW'(acc + 1 < n));
        end
        while (t < total) begin
            in_valid = 1'($urandom);
            bin      = rand_row();
            tick();
            t++;
            chk($sformatf("drain_out_valid t=%0d", t), BW'(out_valid), BW'(1));
            chk($sformatf("drain_bout t=%0d", t), bout, exp_bout(t, n));
            chk($sformatf("drain_done t=%0d", t), BW'(done), BW'(t == total));
            chk($sformatf("drain_in_ready t=%0d", t), BW'(in_ready), '0);
            chk($sformatf("drain_busy t=%0d", t), BW'(busy), BW'(t < total));
        end
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("end_busy", BW'(busy), '0);
        chk("end_out_valid", BW'(out_valid), '0);
        chk("end_done", BW'(done), '0);
        chk("end_bout_held", bout, exp_bout(t, n));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        num_rows = '0;
        in_valid = 1'b0;
        bin      = '0;
`ifdef MEMB_ABORT_EN
        abort    = 1'b0;
`endif
        clear_gaps();

        // Reset held two cycles.
        tick();
        tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();
        check_idle_zero("post_reset");

        // Single row, Bin[i] = i+1.
        for (int i = 0; i < int'(DIM); i++) rows[0][i*BITS_AB +: BITS_AB] = BITS_AB'(i + 1);
        run_matrix(1, 1'b0, 1'b0);

        // Three rows with a two-cycle gap after the first.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < int'(DIM); i++) rows[r][i*BITS_AB +: BITS_AB] = BITS_AB'(10 * (r + 1));
        clear_gaps();
        gaps[1] = 2;
        run_matrix(3, 1'b0, 1'b0);
        clear_gaps();

        // Signed extremes in a checkerboard.
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < int'(DIM); i++)
                rows[r][i*BITS_AB +: BITS_AB] = ((r + i) % 2 == 1) ? BITS_AB'(127) : BITS_AB'(-128);
        run_matrix(4, 1'b0, 1'b0);

        // start with num_rows = 0 is ignored.
        start    = 1'b1;
        num_rows = '0;
        tick();
        tick();
        start = 1'b0;
        chk("zero_rows_busy", BW'(busy), '0);
        chk("zero_rows_in_ready", BW'(in_ready), '0);
        chk("zero_rows_out_valid", BW'(out_valid), '0);

        // start held high throughout FILL/DRAIN must not disturb the sequence.
        for (int r = 0; r < 6; r++) rows[r] = rand_row();
        run_matrix(6, 1'b1, 1'b1);

        // Oversized request clamps to ROWS_MAX rows.
        for (int r = 0; r < int'(ROWS_MAX); r++) rows[r] = rand_row();
        run_matrix(20, 1'b0, 1'b0);

        // Randomized matrices.
        for (int m = 0; m < 4; m++) begin
            for (int r = 0; r < int'(ROWS_MAX); r++) rows[r] = rand_row();
            run_matrix(int'($urandom_range(1, ROWS_MAX)), 1'b1, 1'($urandom));
        end

        // Reset in the middle of DRAIN.
        start    = 1'b1;
        num_rows = ROW_W'(2);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        bin      = rand_row();
        tick();
        bin      = rand_row();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", BW'(busy), BW'(1));
        rst = 1'b1;
        tick();
        check_idle_zero("mid_drain_reset");
        rst = 1'b0;
        tick();
        check_idle_zero("mid_drain_reset_after");

`ifdef MEMB_ABORT_EN
        // Abort after two of four rows.
        start    = 1'b1;
        num_rows = ROW_W'(4);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        bin      = rand_row();
        tick();
        bin      = rand_row();
        tick();
        abort = 1'b1;
        bin   = rand_row();
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle_zero("abort");
        tick();
        check_idle_zero("abort_after");
        for (int i = 0; i < int'(DIM); i++) rows[0][i*BITS_AB +: BITS_AB] = BITS_AB'(i + 1);
        run_matrix(1, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
